instruction_fetch_unit: RTL and testbench

Pipeline stage 1: owns the fetch PC, reads instruction words from instruction memory over a request/acknowledge interface, and presents one instruction plus its PC per cycle to instruction_decode_unit. Absorbs decode stalls in a small prefetch buffer, inserts `NOP` bubbles when no instruction is ready, and redirects on flush (branch/jump taken downstream).

---
 rtl/instruction_fetch_unit_pkg.sv | 28 ++
 rtl/instruction_fetch_unit_fetch_buffer.sv | 55 +++++
 rtl/instruction_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage definitions: NOP encoding, widths, reset vector, buffer depth.
// Define FETCH_BUFFER_EN for a 4-entry prefetch FIFO; otherwise a 1-entry skid register.
package instruction_fetch_unit_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
   localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

`ifdef FETCH_BUFFER_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 1;
`endif

   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   localparam int ENTRY_W = $bits(fetch_entry_t);

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~32'h3;
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// Prefetch FIFO holding {pc, instr} pairs; synchronous clear, async reset.
// Push is accepted on a full buffer only when a pop happens on the same edge.
module fetch_buffer
   import instruction_fetch_unit_pkg::*;
#(
   parameter int ENTRIES = DEPTH,
   parameter int CW      = $clog2(ENTRIES + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic               pop,
   input  logic               clear,
   input  logic [ENTRY_W-1:0] din,
   output logic [ENTRY_W-1:0] dout,
   output logic [CW-1:0]      count
);

   localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   logic [ENTRY_W-1:0] mem [ENTRIES];
   logic [PW-1:0]      rd_ptr;
   logic [PW-1:0]      wr_ptr;
   logic               do_push;
   logic               do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(ENTRIES - 1)) ? '0 : p + PW'(1);
   endfunction

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CW'(ENTRIES)) || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads imem over req/ack, feeds decode one word per cycle.
// Buffer depth follows FETCH_BUFFER_EN (see package); flush redirects via DISCARD.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
   input  logic        clock_i,
   input  logic        reset_i,
   output logic [31:0] imem_addr_o,
   output logic        imem_read_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   output logic [31:0] instruction_o,
   output logic [31:0] pc_o,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] branch_target_i
);

   typedef enum logic {FETCH, DISCARD} state_t;

   localparam int LW = CNT_W + 1;

   state_t           state;
   state_t           state_next;
   logic [31:0]      addr;
   logic [31:0]      addr_next;
   logic [31:0]      target;
   logic [31:0]      target_next;
   logic [31:0]      instr;
   logic [31:0]      instr_next;
   logic [31:0]      pc;
   logic [31:0]      pc_next;
   logic             read;
   logic             read_next;
   logic             ack;
   logic             push;
   logic             pop;
   logic             clear;
   logic [LW-1:0]    level;
   logic [CNT_W-1:0] count;
   fetch_entry_t     buf_in;
   fetch_entry_t     buf_out;

   assign ack           = read && imem_ack_i;
   assign buf_in        = '{pc: addr, instr: imem_data_i};
   assign imem_addr_o   = addr;
   assign imem_read_o   = read;
   assign instruction_o = instr;
   assign pc_o          = pc;

   fetch_buffer #(
      .ENTRIES (DEPTH),
      .CW      (CNT_W)
   ) u_fetch_buffer (
      .clk   (clock_i),
      .rst   (reset_i),
      .push  (push),
      .pop   (pop),
      .clear (clear),
      .din   (buf_in),
      .dout  (buf_out),
      .count (count)
   );

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state  <= FETCH;
         addr   <= RESET_VECTOR;
         target <= RESET_VECTOR;
         read   <= 1'b0;
         instr  <= NOP;
         pc     <= '0;
      end else begin
         state  <= state_next;
         addr   <= addr_next;
         target <= target_next;
         read   <= read_next;
         instr  <= instr_next;
         pc     <= pc_next;
      end
   end

   always_comb begin
      state_next  = state;
      addr_next   = addr;
      target_next = target;
      instr_next  = instr;
      pc_next     = pc;
      read_next   = read && !ack;
      push        = 1'b0;
      pop         = 1'b0;
      clear       = 1'b0;
      level       = {1'b0, count};
      if (flush_i) begin
         clear      = 1'b1;
         instr_next = NOP;
         pc_next    = '0;
         read_next  = 1'b1;
         // an unanswered request must finish at its old address first
         if (read && !ack) begin
            state_next  = DISCARD;
            target_next = word_align(branch_target_i);
         end else begin
            state_next = FETCH;
            addr_next  = word_align(branch_target_i);
         end
      end else begin
         if (!stall_i) begin
            if (count != '0) begin
               pop        = 1'b1;
               instr_next = buf_out.instr;
               pc_next    = buf_out.pc;
            end else if (ack && state == FETCH) begin
               instr_next = imem_data_i;
               pc_next    = addr;
            end else begin
               instr_next = NOP;
               pc_next    = '0;
            end
         end
         if (state == DISCARD) begin
            read_next = 1'b1;
            if (ack) begin
               addr_next  = target;
               state_next = FETCH;
            end
         end else begin
            if (ack) begin
               addr_next = addr + 32'd4;
               push      = stall_i || (count != '0);
            end
            level     = {1'b0, count} + LW'(push) - LW'(pop);
            read_next = (read && !ack) || (level < LW'(DEPTH));
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a scoreboard of fetched words.
// Memory model answers with programmable wait states under a bench-granted ack credit.
module tb_instruction_fetch_unit;
   import instruction_fetch_unit_pkg::*;

`ifdef FETCH_BUFFER_EN
   localparam int D = 4;
`else
   localparam int D = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] target = '0;
   logic        imem_read;
   logic        imem_ack;
   logic        stall = 1'b0;
   logic        flush = 1'b0;

   int total = 0;
   int bad = 0;
   int ws = 0;
   int credit = 0;
   int acks = 0;
   int wcnt = 0;
   int base = 0;
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   function automatic logic [31:0] dat(input logic [31:0] a);
      return a ^ 32'hF000_0000;
   endfunction

   assign imem_data = dat(imem_addr);
   assign imem_ack  = imem_read && (acks < credit) && (wcnt >= ws);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         wcnt <= 0;
      end else if (imem_ack) begin
         wcnt <= 0;
         acks <= acks + 1;
      end else if (imem_read && acks < credit) begin
         wcnt <= wcnt + 1;
      end else begin
         wcnt <= 0;
      end
   end

   instruction_fetch_unit dut (
      .clock_i         (clk),
      .reset_i         (rst),
      .imem_addr_o     (imem_addr),
      .imem_read_o     (imem_read),
      .imem_ack_i      (imem_ack),
      .imem_data_i     (imem_data),
      .instruction_o   (instr),
      .pc_o            (pc),
      .stall_i         (stall),
      .flush_i         (flush),
      .branch_target_i (target)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic expect_words(input logic [31:0] a0, input int n);
      for (int i = 0; i < n; i++)
         exp_q.push_back({a0 + 32'(4 * i), dat(a0 + 32'(4 * i))});
   endtask

   // a word is taken by decode on the next edge when not stalled or flushed
   task automatic mon();
      logic [63:0] e;
      if (!rst && !stall && !flush && instr !== NOP) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected", instr, NOP);
         end else begin
            e = exp_q.pop_front();
            chk("sb_pc", pc, e[63:32]);
            chk("sb_instr", instr, e[31:0]);
         end
      end
   endtask

   task automatic cyc();
      mon();
      @(negedge clk);
      #1;
   endtask

   initial begin
      credit = 4;
      ws = 0;
      expect_words(32'h0, 4);
      cyc();
      chk("rst_instr", instr, NOP);
      chk("rst_pc", pc, 32'h0);
      chk("rst_read", {31'b0, imem_read}, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      rst = 1'b0;
      cyc();
      chk("first_read", {31'b0, imem_read}, 32'h1);
      chk("first_addr", imem_addr, 32'h0);
      chk("first_bubble", instr, NOP);
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk("zw_instr", instr, dat(32'(4 * k)));
         chk("zw_pc", pc, 32'(4 * k));
      end
      cyc();
      chk("zw_idle", instr, NOP);
      chk("zw_idle_addr", imem_addr, 32'h10);
      chk("zw_idle_read", {31'b0, imem_read}, 32'h1);

      ws = 2;
      credit += 3;
      expect_words(32'h10, 3);
      for (int k = 0; k < 3; k++) begin
         for (int w = 0; w < 2; w++) begin
            cyc();
            chk("ws_bubble", instr, NOP);
            chk("ws_addr", imem_addr, 32'h10 + 32'(4 * k));
         end
         cyc();
         chk("ws_instr", instr, dat(32'h10 + 32'(4 * k)));
         chk("ws_pc", pc, 32'h10 + 32'(4 * k));
      end

      ws = 0;
      credit += D + 3;
      expect_words(32'h1c, D + 3);
      base = acks;
      cyc();
      chk("pre_stall", instr, dat(32'h1c));
      stall = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cyc();
         chk("stall_instr", instr, dat(32'h1c));
         chk("stall_pc", pc, 32'h1c);
      end
      chk("stall_reads", 32'(acks - base), 32'(D + 1));
      chk("stall_read_low", {31'b0, imem_read}, 32'h0);
      chk("stall_addr", imem_addr, 32'h1c + 32'(4 * (D + 1)));
      stall = 1'b0;
      cyc();
      chk("resume_instr", instr, dat(32'h20));
      repeat (10) cyc();
      chk("drain1", 32'(exp_q.size()), 32'h0);

      flush = 1'b1;
      target = 32'h0000_0fff;
      cyc();
      chk("disc_instr", instr, NOP);
      chk("disc_read", {31'b0, imem_read}, 32'h1);
      chk("disc_addr", imem_addr, 32'h1c + 32'(4 * (D + 3)));
      target = 32'h0000_0103;
      cyc();
      chk("disc_addr2", imem_addr, 32'h1c + 32'(4 * (D + 3)));
      flush = 1'b0;
      credit += 3;
      expect_words(32'h100, 2);
      cyc();
      chk("disc_drop", instr, NOP);
      chk("redir_addr", imem_addr, 32'h100);
      cyc();
      chk("tgt_instr", instr, dat(32'h100));
      chk("tgt_pc", pc, 32'h100);
      cyc();
      chk("tgt_next", instr, dat(32'h104));
      cyc();

      stall = 1'b1;
      flush = 1'b1;
      target = 32'h0000_0200;
      credit += 1;
      cyc();
      chk("fa_instr", instr, NOP);
      chk("fa_pc", pc, 32'h0);
      chk("fa_addr", imem_addr, 32'h200);
      chk("fa_read", {31'b0, imem_read}, 32'h1);
      flush = 1'b0;
      stall = 1'b0;
      credit += 1;
      cyc();
      chk("fa_after", instr, dat(32'h200));
      chk("fa_after_pc", pc, 32'h200);
      chk("drain2", 32'(exp_q.size()), 32'h0);

      rst = 1'b1;
      #1;
      chk("mid_rst_instr", instr, NOP);
      chk("mid_rst_pc", pc, 32'h0);
      chk("mid_rst_read", {31'b0, imem_read}, 32'h0);
      chk("mid_rst_addr", imem_addr, 32'h0);
      cyc();
      rst = 1'b0;
      credit += 2;
      expect_words(32'h0, 2);
      cyc();
      chk("rf_read", {31'b0, imem_read}, 32'h1);
      chk("rf_addr", imem_addr, 32'h0);
      cyc();
      chk("rf_instr0", instr, dat(32'h0));
      cyc();
      chk("rf_instr1", instr, dat(32'h4));
      repeat (4) cyc();
      chk("drain3", 32'(exp_q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
